// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the clock-divider ratio controller: FSM states,
// default counter width and the smallest legal divide ratio.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned MIN_DIV   = 2;

endpackage

// File: rtl/div_ratio_ctrl_if.sv
// Configuration request channel: valid/ready handshake carrying enable and
// divide ratio, plus the reject pulse returned to the requester.
import div_ctrl_pkg::*;

interface div_ratio_ctrl_if #(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_en,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_en,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/div_ratio_ctrl_core.sv
// Divider datapath: period counter, posedge/negedge phase flops and the
// odd/even output mux. Ratio and odd select are only reloaded at a boundary.
import div_ctrl_pkg::*;

module div_core #(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] div_o
);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             odd_q, odd_d;
  logic             clk_p_q, clk_p_d;
  logic             clk_n_q;

  assign tick_o = run_q && (cnt_q == (n_q - CNT_W'(1)));

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    n_d   = n_q;
    odd_d = odd_q;
    if (stop_i) begin
      run_d = 1'b0;
      cnt_d = '0;
      n_d   = '0;
      odd_d = 1'b0;
    end else if (load_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      n_d   = div_i;
      odd_d = div_i[0];
    end else if (run_q) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
    // clk_p is registered from the next count so it rises on the load edge
    clk_p_d = run_d && (cnt_d < (n_d >> 1));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      odd_q   <= 1'b0;
      clk_p_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      odd_q   <= odd_d;
      clk_p_q <= clk_p_d;
    end
  end

  // Half-cycle extension for odd ratios; always 0 across a period boundary
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      clk_n_q <= 1'b0;
    end else begin
      clk_n_q <= clk_p_q;
    end
  end

  assign clk_o = odd_q ? (clk_p_q | clk_n_q) : clk_p_q;
  assign div_o = n_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Divide-ratio controller: accepts enable/ratio requests, rejects ratios
// below MIN_DIV and defers accepted changes to the next period boundary.
import div_ctrl_pkg::*;

module div_ratio_ctrl #(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  div_ratio_ctrl_if.slave  cfg,
  output logic             clk_out,
  output logic [CNT_W-1:0] div_cur,
  output logic             period_tick
);

  state_e           state_q, state_d;
  logic             pend_en_q, pend_en_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             err_q;

  logic             accept;
  logic             div_ok;
  logic             req_good;
  logic             tick;
  logic             load;
  logic             stop;
  logic [CNT_W-1:0] load_div;

  assign cfg.cfg_ready = (state_q != PEND);
  assign cfg.cfg_err   = err_q;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign div_ok        = (cfg.cfg_div >= CNT_W'(MIN_DIV));
  assign req_good      = accept & div_ok;
  assign period_tick   = tick;

  always_comb begin
    state_d    = state_q;
    pend_en_d  = pend_en_q;
    pend_div_d = pend_div_q;
    load       = 1'b0;
    stop       = 1'b0;
    load_div   = cfg.cfg_div;
    case (state_q)
      IDLE: begin
        if (req_good && cfg.cfg_en) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (req_good) begin
          // A request landing on the last cycle applies directly, no PEND
          if (tick) begin
            if (cfg.cfg_en) begin
              load = 1'b1;
            end else begin
              stop    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            pend_en_d  = cfg.cfg_en;
            pend_div_d = cfg.cfg_div;
            state_d    = PEND;
          end
        end
      end
      PEND: begin
        if (tick) begin
          load_div   = pend_div_q;
          pend_en_d  = 1'b0;
          pend_div_d = '0;
          if (pend_en_q) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            stop    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_en_q  <= 1'b0;
      pend_div_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_en_q  <= pend_en_d;
      pend_div_q <= pend_div_d;
      err_q      <= accept & ~div_ok;
    end
  end

  div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load_i (load),
    .stop_i (stop),
    .div_i  (load_div),
    .clk_o  (clk_out),
    .tick_o (tick),
    .div_o  (div_cur)
  );

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Bench for div_ratio_ctrl: directed scenarios plus random requests, all
// checked against a period/position reference model at half-cycle resolution.
module tb_div_ratio_ctrl;

  localparam int unsigned W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         clk_out;
  logic [W-1:0] div_cur;
  logic         period_tick;

  div_ratio_ctrl_if #(.CNT_W(W)) cfg_if ();

  div_ratio_ctrl #(
    .CNT_W (W)
  ) dut (
    .clk_in      (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_if),
    .clk_out     (clk_out),
    .div_cur     (div_cur),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: running flag, ratio, position in period, pending request
  bit m_run;
  int m_n;
  int m_pos;
  bit m_pv;
  bit m_pen;
  int m_pdiv;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, act, exp);
    end
  endtask

  // Output is high for the first N half-periods of clk_in in each period
  function automatic logic exp_clk(input int half);
    return m_run && ((2 * m_pos + half) < m_n);
  endfunction

  function automatic logic exp_tick();
    return m_run && (m_pos == m_n - 1);
  endfunction

  task automatic model_apply(input bit en, input int div);
    if (en) begin
      m_run = 1'b1;
      m_n   = div;
      m_pos = 0;
    end else begin
      m_run = 1'b0;
      m_n   = 0;
      m_pos = 0;
    end
  endtask

  task automatic model_advance(input bit v, input bit en, input int div);
    bit acc, tick, good;
    acc   = v && !m_pv;
    tick  = exp_tick();
    m_err = acc && (div < 2);
    good  = acc && (div >= 2);
    if (m_run) m_pos = tick ? 0 : m_pos + 1;
    if (good && !m_run) begin
      if (en) model_apply(1'b1, div);
    end else if (good && tick) begin
      model_apply(en, div);
    end else if (good) begin
      m_pv   = 1'b1;
      m_pen  = en;
      m_pdiv = div;
    end else if (tick && m_pv) begin
      model_apply(m_pen, m_pdiv);
      m_pv = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_n = 0; m_pos = 0;
    m_pv = 1'b0; m_pen = 1'b0; m_pdiv = 0; m_err = 1'b0;
  endtask

  task automatic check_posedge();
    check("cfg_ready",   32'(cfg_if.cfg_ready), 32'(!m_pv));
    check("period_tick", 32'(period_tick),      32'(exp_tick()));
    check("div_cur",     32'(div_cur),          32'(m_n));
    check("clk_out_h0",  32'(clk_out),          32'(exp_clk(0)));
    check("cfg_err",     32'(cfg_if.cfg_err),   32'(m_err));
  endtask

  // One clk_in cycle; entered and left at posedge+1
  task automatic step(input bit v, input bit en, input int div);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_en    = en;
    cfg_if.cfg_div   = W'(div);
    @(negedge clk);
    #1;
    check("clk_out_h1", 32'(clk_out), 32'(exp_clk(1)));
    model_advance(v, en, div);
    @(posedge clk);
    #1;
    check_posedge();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  task automatic wait_pos(input int p);
    for (int unsigned i = 0; i < 40; i++) begin
      if (m_run && (m_pos == p)) return;
      step(1'b0, 1'b0, 0);
    end
    check("wait_pos_timeout", 32'(m_pos), 32'(p));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_clk_out", 32'(clk_out),          32'd0);
    check("rst_div_cur", 32'(div_cur),          32'd0);
    check("rst_tick",    32'(period_tick),      32'd0);
    check("rst_ready",   32'(cfg_if.cfg_ready), 32'd1);
    check("rst_err",     32'(cfg_if.cfg_err),   32'd0);
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_en    = 1'b0;
    cfg_if.cfg_div   = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_posedge();
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_en    = 1'b0;
    cfg_if.cfg_div   = '0;
    #2;
    apply_reset();
    idle(3);

    // Even ratio, then change to 7 mid-period (goes through PEND)
    step(1'b1, 1'b1, 4);
    idle(9);
    wait_pos(1);
    step(1'b1, 1'b1, 7);
    idle(16);

    // Request on the last cycle of the period applies with no PEND
    wait_pos(6);
    step(1'b1, 1'b1, 3);
    idle(7);

    // Invalid ratio is rejected, clock undisturbed
    step(1'b1, 1'b1, 1);
    idle(4);
    step(1'b1, 1'b1, 0);
    idle(4);

    // Odd ratio, same-ratio request, then stop mid-period
    step(1'b1, 1'b1, 5);
    idle(12);
    step(1'b1, 1'b1, 5);
    idle(8);
    wait_pos(1);
    step(1'b1, 1'b0, 5);
    idle(8);

    // Asynchronous reset while clk_out is high
    step(1'b1, 1'b1, 6);
    check("pre_rst_high", 32'(clk_out), 32'd1);
    #2;
    apply_reset();
    idle(4);
    step(1'b1, 1'b0, 9);
    idle(3);

    // Random requests
    for (int unsigned i = 0; i < 500; i++) begin
      if ($urandom_range(0, 2) == 0)
        step(1'b1, ($urandom_range(0, 4) != 0), int'($urandom_range(0, 15)));
      else
        step(1'b0, 1'b0, 0);
      if ($urandom_range(0, 199) == 0) apply_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
DIV_RATIO_CTRL -- requirements
Module: div_ratio_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, giving the divide-ratio width; maximum ratio is 2^CNT_W-1.
REQ-002 SHALL have port clk_in, input, 1 bit: source clock; all logic runs on its posedge except the odd-duty flop.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_valid, input, 1 bit: configuration request valid.
REQ-005 SHALL have port cfg_ready, output, 1 bit: configuration request can be accepted.
REQ-006 SHALL have port cfg_en, input, 1 bit: requested enable; 1 = run, 0 = stop.
REQ-007 SHALL have port cfg_div, input, CNT_W bits: requested divide ratio N.
REQ-008 SHALL have port clk_out, output, 1 bit: divided clock.
REQ-009 SHALL have port div_cur, output, CNT_W bits: active ratio; 0 when stopped.
REQ-010 SHALL have port period_tick, output, 1 bit: one-cycle pulse in the last clk_in cycle of each output period.
REQ-011 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an invalid ratio is rejected.

Function
REQ-012 SHALL accept a request on a clk_in posedge when cfg_valid & cfg_ready are both 1.
REQ-013 SHALL implement FSM states IDLE, RUN and PEND.
REQ-014 SHALL drive cfg_ready=1 in IDLE and RUN, and 0 in PEND.
REQ-015 SHALL treat cfg_div in 2..2^CNT_W-1 as valid; 0 and 1 SHALL be accepted but rejected, pulse cfg_err the next cycle and leave state, counter and outputs unchanged.
REQ-016 IDLE: on an accepted valid request with cfg_en=1, SHALL enter RUN next cycle with cnt=0, div_cur=N and the clk_out rise on that same edge (1-cycle latency); an accepted request with cfg_en=0 SHALL be a no-op.
REQ-017 RUN: cnt SHALL count 0..N-1 and wrap to 0; period_tick=1 while cnt==N-1.
REQ-018 Posedge flop clk_p SHALL be high while cnt < floor(N/2).
REQ-019 Negedge flop clk_n SHALL capture clk_p.
REQ-020 clk_out SHALL equal clk_p for even N and clk_p|clk_n for odd N, giving 50% duty, high for N/2 clk_in cycles.
REQ-021 RUN: an accepted request (valid N, or cfg_en=0) SHALL be latched and the FSM SHALL enter PEND, unless cnt==N-1 in that cycle, in which case it SHALL apply at that same boundary and PEND is skipped.
REQ-022 PEND: at the period boundary (cnt==N-1), the latched request SHALL apply.
REQ-023 A pending new N SHALL start the next period with cnt=0, div_cur=N and an odd/even select matching N, then enter RUN.
REQ-024 A pending stop SHALL enter IDLE with clk_p=0, cnt=0, div_cur=0 and clk_out held low.
REQ-025 A ratio change or stop SHALL never truncate a period or produce a clk_out pulse shorter than min(old,new) half-periods.
REQ-026 The odd/even select SHALL change only at a boundary, where clk_n=0 is guaranteed.
REQ-027 A request to the current N in RUN SHALL be accepted, pass through PEND and cause no visible change on clk_out.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, cnt=0, clk_p=0, clk_n=0, clk_out=0, div_cur=0, period_tick=0, cfg_err=0, cfg_ready=1 and clear any pending request.
REQ-029 Reset asserted mid-period SHALL take effect asynchronously, with no completion of the current period.
REQ-030 After deassertion the block SHALL remain in IDLE until a valid enable request is accepted.

Structure
REQ-031 A shared package div_ctrl_pkg SHALL hold the state enum (IDLE/RUN/PEND), the default CNT_W and MIN_DIV=2.
REQ-032 Sub-module div_core SHALL contain cnt, clk_p, clk_n and the clk_out mux, loaded with N and odd at each boundary.
REQ-033 The FSM, request latch and validity check SHALL reside in div_ratio_ctrl.

Verification
REQ-034 Reset, then enable N=4 -> clk_out 2 high/2 low, period_tick every 4th cycle, div_cur=4.
REQ-035 Enable N=5 -> clk_out high exactly 2.5 clk_in cycles per 5-cycle period; no glitch at the clk_p/clk_n overlap.
REQ-036 Running N=4, request N=7 at cnt=1 -> cfg_ready=0 until the boundary; first 7-cycle period starts right after the current 4-cycle period ends.
REQ-037 Request N=3 in the cycle cnt==N-1 -> the next period is 3 cycles, with no PEND cycle (cfg_ready stays 1).
REQ-038 Request cfg_div=1 -> cfg_err pulses one cycle and clk_out is undisturbed.
REQ-039 Stop request mid-period -> current period completes, then clk_out=0 and div_cur=0; rst_n pulse mid-high -> clk_out=0 immediately.
